load_store_unit: RTL

//  Sits between the core datapath and Data_Memory (big-endian byte array, word port, comb read, posedge write).

---
 rtl/load_store_unit_pkg.sv | 39 +++
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit_load_extend.sv | 31 +++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// =============================================================================
// Module   : load_store_unit_pkg
// Brief    : Shared RV32I load/store definitions: funct3 width codes, LSU
//            state encodings and the funct3 legality check.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package load_store_unit_pkg;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU control states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } lsu_state_t;

    // Stores only exist as B/H/W; loads add the unsigned B/H variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// =============================================================================
// Module   : load_store_unit_if
// Brief    : Core-side request/response bundle of the load/store unit.
//            master = core datapath, slave = load_store_unit.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

interface load_store_unit_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          done;
    logic [31:0]   rdata;
    logic          access_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, done, rdata, access_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, done, rdata, access_fault
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
// =============================================================================
// Module   : lsu_load_extend
// Brief    : Picks the addressed byte/half from a big-endian memory word
//            (always the most significant lanes) and sign/zero extends it.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module lsu_load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rd_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    // Width/sign selection; the addressed byte sits in bits [31:24]
    always_comb begin
        rdata_o = mem_rd_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{mem_rd_i[31]}}, mem_rd_i[31:24]};
            F3_H:    rdata_o = {{16{mem_rd_i[31]}}, mem_rd_i[31:16]};
            F3_BU:   rdata_o = {24'd0, mem_rd_i[31:24]};
            F3_HU:   rdata_o = {16'd0, mem_rd_i[31:16]};
            default: rdata_o = mem_rd_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// =============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store unit in front of a word-port, big-endian,
//            byte-addressed memory. Sub-word stores use a registered
//            read-modify-write. Optional feature macro LSU_MISALIGN_TRAP_EN
//            turns misaligned H/W accesses into access faults.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 32
)(
    input  logic                 clk,
    input  logic                 reset,
    load_store_unit_if.slave     core,
    output logic [AW-1:0]        mem_A,
    output logic [31:0]          mem_WD,
    output logic                 mem_WE,
    input  logic [31:0]          mem_RD
);

    localparam logic [AW:0] c_LAST_BYTE = (AW+1)'(MEM_BYTES - 1);
    localparam logic [AW:0] c_WORD_SPAN = (AW+1)'(3);

    lsu_state_t    state_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    funct3_q;
    logic [23:0]   merge_q;
    logic [31:0]   rdata_q;
    logic          done_q;
    logic          fault_q;

    logic [AW:0]   w_end_addr;
    logic          w_misalign;
    logic          w_fault;
    logic [31:0]   w_ext;

    // Fault decision on the incoming request; the last byte touched is
    // computed one bit wider so the range check cannot wrap.
    assign w_end_addr = {1'b0, core.req_addr} + c_WORD_SPAN;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (((core.req_funct3 == F3_H) || (core.req_funct3 == F3_HU)) && core.req_addr[0])
                     || ((core.req_funct3 == F3_W) && (core.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = (w_end_addr > c_LAST_BYTE)
                  || !f3_legal(core.req_we, core.req_funct3)
                  || w_misalign;

    lsu_load_extend u_ext (
        .mem_rd_i (mem_RD),
        .funct3_i (funct3_q),
        .rdata_o  (w_ext)
    );

    // Control FSM with latched request and registered responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (core.req_valid) begin
                        addr_q   <= core.req_addr;
                        wdata_q  <= core.req_wdata;
                        funct3_q <= core.req_funct3;
                        if (w_fault) begin
                            // No memory access; report at once and stay idle
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (!core.req_we) begin
                            state_q <= S_LOAD;
                        end else if (core.req_funct3 == F3_W) begin
                            state_q <= S_STORE;
                        end else begin
                            state_q <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rdata_q <= w_ext;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_STORE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_RMW_RD: begin
                    // Only the bytes that survive the merge are kept
                    merge_q <= mem_RD[23:0];
                    state_q <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write data: full word for SW, merged word for the RMW write cycle
    always_comb begin
        mem_WD = wdata_q;
        if (state_q == S_RMW_WR) begin
            if (funct3_q == F3_B) begin
                mem_WD = {wdata_q[7:0], merge_q};
            end else begin
                mem_WD = {wdata_q[15:0], merge_q[15:0]};
            end
        end
    end

    assign mem_A  = addr_q;
    assign mem_WE = (state_q == S_STORE) || (state_q == S_RMW_WR);

    assign core.req_ready    = (state_q == S_IDLE);
    assign core.done         = done_q;
    assign core.rdata        = rdata_q;
    assign core.access_fault = fault_q;

endmodule

`default_nettype wire
